// File: rtl/cam_frame_capture_gate.sv
// Per-camera frame gate: admits whole frames on trigger or continuously,
// and measures frame_start rate over a 1 s window.
module cam_frame_capture_gate #(
    parameter int DATA_WIDTH  = 64,
    parameter int CLK_FREQ_HZ = 100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  trigger_capture_frame,
    input  logic                  continuous,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  capture_busy,
    output logic                  capture_done,
    output logic [31:0]           frames_per_second,
    output logic [31:0]           frames_captured
);

    localparam int WIN_W = $clog2(CLK_FREQ_HZ);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_FREQ_HZ - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state_q, state_d;
    logic                  trig_q;
    logic                  cont_q, cont_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  done_q, done_d;
    logic [31:0]           fps_q, fps_d;
    logic [31:0]           fcap_q, fcap_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [31:0]           fcnt_q, fcnt_d;
    logic                  trig_edge;
    logic                  pass;
    logic                  wrap;
    logic [31:0]           fs_sum;

    assign trig_edge = trigger_capture_frame & ~trig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            trig_q      <= 1'b0;
            cont_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            fps_q       <= '0;
            fcap_q      <= '0;
            win_q       <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trigger_capture_frame;
            cont_q      <= cont_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            fps_q       <= fps_d;
            fcap_q      <= fcap_d;
            win_q       <= win_d;
            fcnt_q      <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        case (state_q)
            IDLE: begin
                if (trig_edge || continuous) begin
                    state_d = ARMED;
                    cont_d  = continuous;
                end
            end
            ARMED: begin
                if (frame_start) state_d = CAPTURE;
            end
            CAPTURE: begin
                // end wins over a coincident start; the start only counts if we re-arm
                if (frame_end) begin
                    if (cont_q && continuous) begin
                        state_d = frame_start ? CAPTURE : ARMED;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pass         = (state_q == CAPTURE) || (state_q == ARMED && frame_start);
        out_valid_d  = in_valid && pass;
        out_data_d   = in_valid ? in_data : out_data_q;
        capture_busy = (state_q == ARMED) || (state_q == CAPTURE);
        done_d       = done_q;
        if (state_q == IDLE && trig_edge) begin
            done_d = 1'b0;
        end else if (state_q == DONE) begin
            done_d = 1'b1;
        end
        fcap_d = fcap_q;
        if (state_q == CAPTURE && frame_end) fcap_d = fcap_q + 32'd1;
    end

    always_comb begin
        wrap   = (win_q == WIN_LAST);
        win_d  = wrap ? '0 : win_q + WIN_W'(1);
        fs_sum = (frame_start && fcnt_q != '1) ? fcnt_q + 32'd1 : fcnt_q;
        // a start on the wrap cycle still belongs to the closing window
        if (wrap) begin
            fps_d  = fs_sum;
            fcnt_d = '0;
        end else begin
            fps_d  = fps_q;
            fcnt_d = fs_sum;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign capture_done      = done_q;
    assign frames_per_second = fps_q;
    assign frames_captured   = fcap_q;

endmodule

// File: tb/tb_cam_frame_capture_gate.sv
// Bench for cam_frame_capture_gate: frame-level pixel scoreboard and
// per-window frame_start counting model.
module tb_cam_frame_capture_gate;

    localparam int DW = 64;
    localparam int CF = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_end = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          trigger_capture_frame = 1'b0;
    logic          continuous = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          capture_busy;
    logic          capture_done;
    logic [31:0]   frames_per_second;
    logic [31:0]   frames_captured;

    cam_frame_capture_gate #(
        .DATA_WIDTH (DW),
        .CLK_FREQ_HZ(CF)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .frame_start          (frame_start),
        .frame_end            (frame_end),
        .in_valid             (in_valid),
        .in_data              (in_data),
        .trigger_capture_frame(trigger_capture_frame),
        .continuous           (continuous),
        .out_valid            (out_valid),
        .out_data             (out_data),
        .capture_busy         (capture_busy),
        .capture_done         (capture_done),
        .frames_per_second    (frames_per_second),
        .frames_captured      (frames_captured)
    );

    always #5 clk = ~clk;

    int            vecs = 0;
    int            errs = 0;
    int            cyc = 0;
    int            fc_exp = 0;
    int            fs_log[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] last_v = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int starts_in(input int lo, input int hi);
        int n = 0;
        foreach (fs_log[i]) if (fs_log[i] >= lo && fs_log[i] <= hi) n++;
        return n;
    endfunction

    task automatic tick();
        if (frame_start) fs_log.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) got_q.push_back(out_data);
        if (cyc % CF == 0)
            chk("fps_window", 64'(frames_per_second),
                64'(starts_in(cyc - CF, cyc - 1)));
    endtask

    task automatic drive(input bit fs, input bit fe, input bit v,
                         input bit pass);
        frame_start = fs;
        frame_end   = fe;
        in_valid    = v;
        in_data     = {$urandom, $urandom};
        if (v) last_v = in_data;
        if (v && pass) exp_q.push_back(in_data);
        tick();
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_frame(input int npix, input bit pass,
                              input int trig_at, input int cont_off_at);
        bit tail = 1'($urandom_range(0, 1));
        for (int i = 0; i < npix; i++) begin
            if (i > 0) repeat ($urandom_range(0, 2)) drive(0, 0, 0, 0);
            if (i == trig_at) trigger_capture_frame = ~trigger_capture_frame;
            if (i == cont_off_at) continuous = 1'b0;
            drive(i == 0, tail && (i == npix - 1), 1'b1, pass);
        end
        if (!tail) drive(0, 1, 0, 0);
    endtask

    task automatic compare_pixels(input string tag);
        int n;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_data"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic release_rst();
        rst    = 1'b0;
        cyc    = 0;
        fc_exp = 0;
        fs_log.delete();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        in_valid    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        release_rst();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_busy", 64'(capture_busy), 64'(0));
        chk("rst_done", 64'(capture_done), 64'(0));
        chk("rst_fps", 64'(frames_per_second), 64'(0));
        chk("rst_fcap", 64'(frames_captured), 64'(0));

        // single capture: trigger, then three frames, only the first passes
        gap(4);
        chk("s1_idle_busy", 64'(capture_busy), 64'(0));
        trigger_capture_frame = 1'b1;
        drive(0, 0, 0, 0);
        chk("s1_trig_busy", 64'(capture_busy), 64'(1));
        gap(3);
        send_frame(8, 1, -1, -1);
        fc_exp++;
        chk("s1_done_state_busy", 64'(capture_busy), 64'(0));
        chk("s1_done_not_yet", 64'(capture_done), 64'(0));
        drive(0, 0, 0, 0);
        chk("s1_done", 64'(capture_done), 64'(1));
        chk("s1_out_data_hold", out_data, last_v);
        chk("s1_fcap", 64'(frames_captured), 64'(fc_exp));
        gap(3);
        send_frame(8, 0, -1, -1);
        gap(3);
        send_frame(8, 0, -1, -1);
        chk("s1_fcap_after", 64'(frames_captured), 64'(fc_exp));
        compare_pixels("s1_pix");

        // trigger mid-frame: frame 1 blocked, frame 2 passed
        trigger_capture_frame = 1'b0;
        gap(3);
        send_frame(8, 0, 4, -1);
        chk("s2_armed_busy", 64'(capture_busy), 64'(1));
        chk("s2_done_cleared", 64'(capture_done), 64'(0));
        trigger_capture_frame = 1'b0;
        gap(2);
        send_frame(8, 1, 2, -1);
        fc_exp++;
        chk("s2_end_busy", 64'(capture_busy), 64'(0));
        drive(0, 0, 0, 0);
        chk("s2_done", 64'(capture_done), 64'(1));
        chk("s2_fcap", 64'(frames_captured), 64'(fc_exp));
        gap(3);
        send_frame(8, 0, -1, -1);
        chk("s2_no_queued_trig", 64'(capture_busy), 64'(0));
        compare_pixels("s2_pix");

        // continuous mode for four frames, cleared during the fourth
        trigger_capture_frame = 1'b0;
        gap(2);
        continuous = 1'b1;
        trigger_capture_frame = 1'b1;
        drive(0, 0, 0, 0);
        chk("s3_busy", 64'(capture_busy), 64'(1));
        chk("s3_done_cleared", 64'(capture_done), 64'(0));
        for (int f = 0; f < 3; f++) begin
            gap(3);
            send_frame(8, 1, -1, -1);
            fc_exp++;
            chk("s3_rearmed", 64'(capture_busy), 64'(1));
        end
        chk("s3_fcap_mid", 64'(frames_captured), 64'(fc_exp));
        chk("s3_done_mid", 64'(capture_done), 64'(0));
        gap(3);
        send_frame(8, 1, -1, 3);
        fc_exp++;
        chk("s3_end_busy", 64'(capture_busy), 64'(0));
        drive(0, 0, 0, 0);
        chk("s3_done", 64'(capture_done), 64'(1));
        chk("s3_fcap", 64'(frames_captured), 64'(fc_exp));
        gap(3);
        send_frame(8, 0, -1, -1);
        compare_pixels("s3_pix");

        // lost frame_end, then end+start in one cycle, continuous
        trigger_capture_frame = 1'b0;
        gap(2);
        continuous = 1'b1;
        gap(2);
        drive(1, 0, 1, 1);
        repeat (5) drive(0, 0, 1, 1);
        drive(1, 0, 1, 1);
        repeat (5) drive(0, 0, 1, 1);
        drive(1, 1, 1, 1);
        fc_exp++;
        repeat (5) drive(0, 0, 1, 1);
        drive(0, 1, 1, 1);
        fc_exp++;
        chk("s4_busy", 64'(capture_busy), 64'(1));
        chk("s4_fcap", 64'(frames_captured), 64'(fc_exp));
        gap(3);
        send_frame(8, 1, -1, 2);
        fc_exp++;
        drive(0, 0, 0, 0);
        chk("s4_done", 64'(capture_done), 64'(1));
        chk("s4_fcap_end", 64'(frames_captured), 64'(fc_exp));
        compare_pixels("s4_pix");

        // reset in the middle of a captured frame
        continuous = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 0, 1, 1);
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 1);
        rst         = 1'b1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'(0));
        chk("mr_out_data", out_data, 64'(0));
        chk("mr_busy", 64'(capture_busy), 64'(0));
        chk("mr_done", 64'(capture_done), 64'(0));
        chk("mr_fps", 64'(frames_per_second), 64'(0));
        chk("mr_fcap", 64'(frames_captured), 64'(0));
        @(posedge clk);
        #1;
        release_rst();
        repeat (4) drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        gap(2);
        send_frame(8, 1, -1, 3);
        fc_exp++;
        drive(0, 0, 0, 0);
        chk("mr_done_after", 64'(capture_done), 64'(1));
        chk("mr_fcap_after", 64'(frames_captured), 64'(fc_exp));
        compare_pixels("mr_pix");

        // frame rate: a start every 20 cycles, one landing on the wrap cycle
        continuous            = 1'b0;
        trigger_capture_frame = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * CF; i++) begin
            drive(i % 20 == 19, 0, 0, 0);
            if (cyc == CF - 1)
                chk("fps_first_pending", 64'(frames_per_second), 64'(0));
            if (cyc == CF)
                chk("fps_first", 64'(frames_per_second), 64'(5));
            if (cyc == CF + CF / 2)
                chk("fps_hold", 64'(frames_per_second), 64'(5));
        end
        for (int i = 0; i < CF; i++)
            drive($urandom_range(0, 3) == 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
